// File: rtl/pwm_duty_ramp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_duty_ramp_pkg
// Brief   : Shared duty type and ramp FSM encoding for the PWM sequencers.
// Revision: 1.0
// ============================================================================
package pwm_duty_ramp_pkg;

    localparam int unsigned C_DUTY_WIDTH = 4;

    typedef logic [C_DUTY_WIDTH-1:0] duty_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2
    } ramp_state_e;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned count_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_duty_ramp_if.sv
`default_nettype none
// ============================================================================
// Module  : pwm_duty_ramp_if
// Brief   : Target handshake and PWM generator control bundle for the ramp.
// Revision: 1.0
// ============================================================================
interface pwm_duty_ramp_if #(
    parameter int unsigned DUTY_WIDTH = 4
);
    logic [DUTY_WIDTH-1:0] target_duty;
    logic                  target_valid;
    logic                  target_ready;
    logic                  period_end;
    logic [DUTY_WIDTH-1:0] pwm_duty_cycle;
    logic                  update_parameters;
    logic                  busy;
    logic                  done;

    modport master (
        output target_duty,
        output target_valid,
        output period_end,
        input  target_ready,
        input  pwm_duty_cycle,
        input  update_parameters,
        input  busy,
        input  done
    );

    modport slave (
        input  target_duty,
        input  target_valid,
        input  period_end,
        output target_ready,
        output pwm_duty_cycle,
        output update_parameters,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/pwm_duty_ramp_period_divider.sv
`default_nettype none
// ============================================================================
// Module  : pwm_period_divider
// Brief   : Counts period_end pulses and ticks on every PERIODS-th one.
// Revision: 1.0
// ============================================================================
module pwm_period_divider
    import pwm_duty_ramp_pkg::*;
#(
    parameter int unsigned PERIODS = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    input  wire logic i_period_end,
    output logic      o_tick
);

    localparam int unsigned   c_cnt_w = count_width(PERIODS);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(PERIODS - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               w_hit;

    // Tick is combinational so the consumer can act on the qualifying pulse's edge.
    assign w_hit  = i_enable && i_period_end;
    assign o_tick = w_hit && (r_count == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (w_hit) begin
            r_count <= (r_count == c_last) ? '0 : r_count + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module  : pwm_duty_ramp
// Brief   : Steps a PWM generator's duty toward an accepted target, one
//           saturating step every STEP_PERIODS PWM periods.
// Revision: 1.0
// ============================================================================
module pwm_duty_ramp
    import pwm_duty_ramp_pkg::*;
#(
    parameter int unsigned DUTY_WIDTH   = 4,
    parameter int unsigned MAX_DUTY     = 8,
    parameter int unsigned INITIAL_DUTY = 0,
    parameter int unsigned STEP_SIZE    = 1,
    parameter int unsigned STEP_PERIODS = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    pwm_duty_ramp_if.slave ramp
);

    localparam logic [DUTY_WIDTH-1:0] c_max_duty  = DUTY_WIDTH'(MAX_DUTY);
    localparam logic [DUTY_WIDTH-1:0] c_init_duty = DUTY_WIDTH'(INITIAL_DUTY);
    localparam logic [DUTY_WIDTH:0]   c_step      = (DUTY_WIDTH + 1)'(STEP_SIZE);

    ramp_state_e r_state;
    ramp_state_e w_state_next;

    logic [DUTY_WIDTH-1:0] r_tgt;
    logic [DUTY_WIDTH-1:0] r_duty;
    logic                  r_done;

    logic [DUTY_WIDTH-1:0] w_tgt_clamped;
    logic [DUTY_WIDTH:0]   w_cur_ext;
    logic [DUTY_WIDTH:0]   w_tgt_ext;
    logic [DUTY_WIDTH:0]   w_sum;
    logic [DUTY_WIDTH:0]   w_nxt_ext;
    logic [DUTY_WIDTH-1:0] w_nxt;
    logic                  w_accept;
    logic                  w_same;
    logic                  w_tick;
    logic                  w_step_fire;
    logic                  w_div_en;

    assign w_tgt_clamped = (ramp.target_duty > c_max_duty) ? c_max_duty : ramp.target_duty;
    assign w_accept      = (r_state == IDLE) && ramp.target_valid;
    assign w_same        = (w_tgt_clamped == r_duty);
    assign w_div_en      = (r_state != IDLE);

    // A tick landing on STEP (only possible with very short periods) still
    // produces a step so that no period is lost.
    assign w_step_fire = w_tick && ((r_state == WAIT) ||
                                    ((r_state == STEP) && (r_duty != r_tgt)));

    pwm_period_divider #(
        .PERIODS (STEP_PERIODS)
    ) u_divider (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (w_accept),
        .i_enable     (w_div_en),
        .i_period_end (ramp.period_end),
        .o_tick       (w_tick)
    );

    // Saturating step in one extra bit so neither direction can wrap.
    always_comb begin
        w_cur_ext = {1'b0, r_duty};
        w_tgt_ext = {1'b0, r_tgt};
        w_sum     = w_cur_ext + c_step;
        if (r_tgt > r_duty) begin
            w_nxt_ext = (w_sum > w_tgt_ext) ? w_tgt_ext : w_sum;
        end else begin
            w_nxt_ext = (w_cur_ext < (w_tgt_ext + c_step)) ? w_tgt_ext : (w_cur_ext - c_step);
        end
        w_nxt = DUTY_WIDTH'(w_nxt_ext);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_same) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (w_step_fire) begin
                    w_state_next = STEP;
                end
            end
            STEP: begin
                if (w_step_fire) begin
                    w_state_next = STEP;
                end else if (r_duty == r_tgt) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = WAIT;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Duty is registered on the step edge so it is aligned with the STEP-cycle update pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tgt  <= c_init_duty;
            r_duty <= c_init_duty;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_tgt  <= w_tgt_clamped;
                r_done <= w_same;
            end
            if (w_step_fire) begin
                r_duty <= w_nxt;
                r_done <= (w_nxt == r_tgt);
            end
        end
    end

    always_comb begin
        ramp.target_ready      = 1'b0;
        ramp.busy              = 1'b0;
        ramp.update_parameters = 1'b0;
        ramp.done              = r_done;
        ramp.pwm_duty_cycle    = r_duty;
        case (r_state)
            IDLE:    ramp.target_ready = 1'b1;
            WAIT:    ramp.busy = 1'b1;
            STEP: begin
                ramp.busy              = 1'b1;
                ramp.update_parameters = 1'b1;
            end
            default: ramp.target_ready = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_duty_ramp
// Brief   : Randomized self-checking bench for pwm_duty_ramp with a period-8 pulse source.
// Revision: 1.0
// ============================================================================
module tb_pwm_duty_ramp;

    localparam int DW       = 4;
    localparam int MAXD     = 8;
    localparam int STEP     = 3;
    localparam int NPER     = 2;
    localparam int PWM_PER  = 8;

    logic clk;
    logic reset;

    pwm_duty_ramp_if #(.DUTY_WIDTH(DW)) rif ();

    pwm_duty_ramp #(
        .DUTY_WIDTH   (DW),
        .MAX_DUTY     (MAXD),
        .INITIAL_DUTY (0),
        .STEP_SIZE    (STEP),
        .STEP_PERIODS (NPER)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ramp  (rif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int model_duty = 0;
    int pe_count   = 0;
    bit eq_expected = 0;
    int pe_phase   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Free-running generator period marker.
    initial begin
        rif.period_end = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pe_phase = (pe_phase + 1) % PWM_PER;
            rif.period_end = (pe_phase == PWM_PER - 1);
        end
    end

    // Monitor: every update must match the next planned duty, be spaced by NPER periods,
    // and done must appear only with the final step or an equal-target accept.
    always @(negedge clk) begin
        if (!reset) begin
            if (!rif.busy) pe_count = 0;
            if (rif.update_parameters) begin
                check_eq("upd_not_on_period_end", rif.period_end, 0);
                check_eq("upd_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check_eq("upd_duty", rif.pwm_duty_cycle, exp_q.pop_front());
                    check_eq("upd_spacing", pe_count, NPER);
                    check_eq("done_on_last", rif.done, int'(exp_q.size() == 0));
                end
                pe_count = 0;
            end else if (eq_expected) begin
                check_eq("eq_done", rif.done, 1);
                check_eq("eq_busy", rif.busy, 0);
                eq_expected = 0;
            end else begin
                check_eq("done_idle", rif.done, 0);
            end
            if (rif.busy && rif.period_end) pe_count++;
        end
    end

    // Called at posedge+1 while the DUT is idle.
    task automatic send_target(input int t, input int hold_cycles);
        int tc;
        int cur;
        tc = (t > MAXD) ? MAXD : t;
        check_eq("ready_before_send", rif.target_ready, 1);
        rif.target_duty  = DW'(t);
        rif.target_valid = 1'b1;
        @(posedge clk);
        #1;
        if (tc == model_duty) begin
            eq_expected = 1;
        end else begin
            cur = model_duty;
            while (cur != tc) begin
                if (tc > cur) cur = (cur + STEP > tc) ? tc : cur + STEP;
                else          cur = (cur - STEP < tc) ? tc : cur - STEP;
                exp_q.push_back(cur);
            end
            model_duty = tc;
        end
        for (int i = 0; i < hold_cycles; i++) begin
            rif.target_duty = DW'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        rif.target_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (!rif.busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check_eq("ramp_finished", ok, 1);
        check_eq("final_duty", rif.pwm_duty_cycle, model_duty);
        check_eq("ready_idle", rif.target_ready, 1);
    endtask

    initial begin
        bit hit;
        reset            = 1'b1;
        rif.target_valid = 1'b0;
        rif.target_duty  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_duty", rif.pwm_duty_cycle, 0);
        check_eq("rst_busy", rif.busy, 0);
        check_eq("rst_update", rif.update_parameters, 0);
        check_eq("rst_done", rif.done, 0);
        check_eq("rst_ready", rif.target_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed: up, saturated down, equal target, clamped target with valid held.
        send_target(6, 0);  wait_idle();
        send_target(2, 0);  wait_idle();
        send_target(2, 0);  wait_idle();
        send_target(15, 5); wait_idle();

        for (int n = 0; n < 20; n++) begin
            send_target(int'($urandom_range(0, 15)), 0);
            wait_idle();
        end

        // Asynchronous reset in the middle of a 0 -> 6 ramp.
        send_target(0, 0); wait_idle();
        send_target(6, 0);
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (rif.pwm_duty_cycle == 3) begin
                hit = 1;
                break;
            end
        end
        check_eq("mid_ramp_reached", hit, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        model_duty  = 0;
        eq_expected = 0;
        #1;
        check_eq("async_rst_duty", rif.pwm_duty_cycle, 0);
        check_eq("async_rst_busy", rif.busy, 0);
        check_eq("async_rst_update", rif.update_parameters, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", rif.target_ready, 1);
        @(posedge clk);
        #1;
        send_target(7, 0); wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
